// File: rtl/config_loader_pkg.sv
// rtl/config_loader_pkg.sv - state encoding and CRC constants shared by the config stream loader
package config_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    SHIFT,
    CHECK,
    DONE
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/crc16_ccitt_byte.sv
// rtl/crc16_ccitt_byte.sv - combinational CRC-16-CCITT update over one byte, MSB first
module crc16_ccitt_byte
  import config_loader_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] next_crc
);

  always_comb begin
    next_crc = crc;
    for (int i = 7; i >= 0; i--) begin
      if (next_crc[15] ^ data[i]) next_crc = {next_crc[14:0], 1'b0} ^ CRC_POLY;
      else                        next_crc = {next_crc[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/config_stream_loader.sv
// rtl/config_stream_loader.sv - byte stream to serial config bitstream loader
// Optional trailing CRC-16 check is enabled by defining CONFIG_LOADER_CRC_EN.
module config_stream_loader
  import config_loader_pkg::*;
#(
  parameter int CONFIG_WIDTH = 1602
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       cfg_bit,
  output logic       cfg_enable,
  output logic       cfg_nreset,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CNT_W = $clog2(CONFIG_WIDTH + 1);

  state_t           state;
  logic [CNT_W-1:0] remaining;   // config bits not yet presented on cfg_bit
  logic [6:0]       shreg;
  logic [2:0]       bits_left;
  logic             accept;

  assign accept = s_valid & s_ready;

`ifdef CONFIG_LOADER_CRC_EN
  logic [15:0] crc_q;
  logic [15:0] crc_next;
  logic [7:0]  crc_hi;
  logic        crc_phase;
  logic        wipe;

  crc16_ccitt_byte u_crc (
    .crc      (crc_q),
    .data     (s_data),
    .next_crc (crc_next)
  );
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= '0;
      shreg      <= '0;
      bits_left  <= '0;
      s_ready    <= 1'b0;
      cfg_bit    <= 1'b0;
      cfg_enable <= 1'b0;
      cfg_nreset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
      crc_q      <= CRC_INIT;
      crc_hi     <= '0;
      crc_phase  <= 1'b0;
      wipe       <= 1'b0;
`endif
    end else if (state == IDLE || state == DONE) begin
      if (start) begin
        state      <= CLEAR;
        cfg_nreset <= 1'b0;
        busy       <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
      end
    end else if (abort) begin
      // Fabric is left partially loaded; only the error flag records it.
      state      <= IDLE;
      s_ready    <= 1'b0;
      cfg_bit    <= 1'b0;
      cfg_enable <= 1'b0;
      cfg_nreset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b1;
`ifdef CONFIG_LOADER_CRC_EN
      wipe       <= 1'b0;
`endif
    end else begin
      case (state)
        CLEAR: begin
          cfg_nreset <= 1'b1;
          s_ready    <= 1'b1;
          remaining  <= CNT_W'(CONFIG_WIDTH);
          state      <= FETCH;
`ifdef CONFIG_LOADER_CRC_EN
          crc_q      <= CRC_INIT;
`endif
        end
        FETCH: begin
          if (accept) begin
            s_ready    <= 1'b0;
            cfg_enable <= 1'b1;
            cfg_bit    <= s_data[7];
            shreg      <= s_data[6:0];
            bits_left  <= 3'd7;
            remaining  <= remaining - 1'b1;
            state      <= SHIFT;
`ifdef CONFIG_LOADER_CRC_EN
            crc_q      <= crc_next;
`endif
          end
        end
        SHIFT: begin
          if (remaining != '0 && bits_left != 3'd0) begin
            cfg_bit   <= shreg[6];
            shreg     <= {shreg[5:0], 1'b0};
            bits_left <= bits_left - 3'd1;
            remaining <= remaining - 1'b1;
          end else begin
            cfg_enable <= 1'b0;
            cfg_bit    <= 1'b0;
            if (remaining != '0) begin
              s_ready <= 1'b1;
              state   <= FETCH;
            end else begin
`ifdef CONFIG_LOADER_CRC_EN
              s_ready   <= 1'b1;
              crc_phase <= 1'b0;
              state     <= CHECK;
`else
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
`endif
            end
          end
        end
`ifdef CONFIG_LOADER_CRC_EN
        CHECK: begin
          if (wipe) begin
            cfg_nreset <= 1'b1;
            wipe       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            error      <= 1'b1;
            state      <= IDLE;
          end else if (accept) begin
            if (!crc_phase) begin
              crc_hi    <= s_data;
              crc_phase <= 1'b1;
            end else begin
              s_ready <= 1'b0;
              if ({crc_hi, s_data} == crc_q) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end else begin
                // Corrupt image: clear the fabric before reporting failure.
                cfg_nreset <= 1'b0;
                wipe       <= 1'b1;
              end
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_stream_loader.sv
// tb/tb_config_stream_loader.sv - randomized self-checking bench for config_stream_loader
module tb_config_stream_loader;

  localparam int W  = 1602;
  localparam int WS = 10;
  localparam int NB = (W + 7) / 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready, cfg_bit, cfg_enable, cfg_nreset, busy, done, error;

  logic       start_s = 1'b0, abort_s = 1'b0, s_valid_s = 1'b0;
  logic [7:0] s_data_s = 8'h00;
  logic       s_ready_s, cfg_bit_s, cfg_enable_s, cfg_nreset_s, busy_s, done_s, error_s;

  int checks = 0;
  int errors = 0;
  int en_total = 0, clr_total = 0, en_s_total = 0;
  bit bit_q[$];
  bit bit_s_q[$];

  always #5 clock = ~clock;

  config_stream_loader #(.CONFIG_WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_bit(cfg_bit), .cfg_enable(cfg_enable), .cfg_nreset(cfg_nreset),
    .busy(busy), .done(done), .error(error)
  );

  config_stream_loader #(.CONFIG_WIDTH(WS)) dut_s (
    .clock(clock), .reset(reset), .start(start_s), .abort(abort_s),
    .s_data(s_data_s), .s_valid(s_valid_s), .s_ready(s_ready_s),
    .cfg_bit(cfg_bit_s), .cfg_enable(cfg_enable_s), .cfg_nreset(cfg_nreset_s),
    .busy(busy_s), .done(done_s), .error(error_s)
  );

  // Fabric-side observer: what the shift register would see.
  always @(negedge clock) begin
    if (cfg_enable) begin
      en_total++;
      bit_q.push_back(cfg_bit);
    end
    if (!cfg_nreset) clr_total++;
    if (cfg_enable_s) begin
      en_s_total++;
      bit_s_q.push_back(cfg_bit_s);
    end
  end

`ifdef CONFIG_LOADER_CRC_EN
  function automatic logic [15:0] crc_ref(input logic [7:0] m[$]);
    int c;
    c = 'hFFFF;
    for (int i = 0; i < m.size(); i++) begin
      for (int k = 7; k >= 0; k--) begin
        int fb;
        fb = ((c >> 15) & 1) ^ ((int'(m[i]) >> k) & 1);
        c  = (c << 1) & 'hFFFF;
        if (fb != 0) c = c ^ 'h1021;
      end
    end
    return c[15:0];
  endfunction
`endif

  task automatic gen_bytes(output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < NB; i++) q.push_back(8'($urandom));
  endtask

  task automatic push_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) @(negedge clock);
    @(negedge clock);
    s_valid = 1'b1;
    s_data  = b;
    t = 0;
    while (s_ready !== 1'b1 && t < 40) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_timeout s_ready=%b required=1", s_ready);
    end
    @(posedge clock);
    #1 s_valid = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] bytes[$], input int gap_max, input bit spam,
                         input bit corrupt, input string name);
    int en0, clr0, base, t, bad;
    logic [7:0] cur;
    logic [15:0] crc;
    @(posedge clock);
    en0  = en_total;
    clr0 = clr_total;
    base = bit_q.size();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    checks++;
    if (busy !== 1'b1 || error !== 1'b0 || done !== 1'b0 || cfg_nreset !== 1'b0) begin
      errors++;
      $display("FAIL %s_start busy=%b error=%b done=%b nreset=%b required 1 0 0 0",
               name, busy, error, done, cfg_nreset);
    end
    for (int i = 0; i < bytes.size(); i++) begin
      if (spam && (i % 40) == 7) begin
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
      end
      push_byte(bytes[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    end
    crc = 16'h0;
`ifdef CONFIG_LOADER_CRC_EN
    crc = crc_ref(bytes);
    push_byte(crc[15:8], 0);
    push_byte(corrupt ? (crc[7:0] ^ 8'hFF) : crc[7:0], 0);
`endif
    t = 0;
    @(negedge clock);
    while (done !== 1'b1 && error !== 1'b1 && t < 60) begin
      @(negedge clock);
      t++;
    end
    @(posedge clock);
    #1;
    checks++;
    if (done !== 1'b1 || error !== corrupt || busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_end done=%b error=%b busy=%b s_ready=%b required 1 %b 0 0 (crc %h)",
               name, done, error, busy, s_ready, corrupt, crc);
    end
    checks++;
    if (en_total - en0 != W) begin
      errors++;
      $display("FAIL %s_enable_count got=%0d required=%0d", name, en_total - en0, W);
    end
    checks++;
    if (clr_total - clr0 != 1 + int'(corrupt)) begin
      errors++;
      $display("FAIL %s_clear_cycles got=%0d required=%0d", name, clr_total - clr0, 1 + int'(corrupt));
    end
    bad = 0;
    if (bit_q.size() < base + W) bad = W;
    else begin
      for (int i = 0; i < W; i++) begin
        cur = bytes[i / 8];
        if (bit_q[base + i] !== cur[7 - (i % 8)]) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_bitstream wrong_bits=%0d required=0", name, bad);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if ({s_ready, cfg_bit, cfg_enable, cfg_nreset, busy, done, error} !== 7'b0001000) begin
      errors++;
      $display("FAIL reset_values got=%b required=0001000",
               {s_ready, cfg_bit, cfg_enable, cfg_nreset, busy, done, error});
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({s_ready, cfg_enable, cfg_nreset, busy, done, error} !== 6'b001000) begin
      errors++;
      $display("FAIL idle_values got=%b required=001000",
               {s_ready, cfg_enable, cfg_nreset, busy, done, error});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    q = {};
    for (int i = 0; i < NB; i++) q.push_back(8'hA5);
    do_load(q, 0, 1'b0, 1'b0, "a5");
  endtask

  task automatic test_random_loads();
    logic [7:0] q[$];
    for (int r = 0; r < 2; r++) begin
      gen_bytes(q);
      do_load(q, 3, 1'b0, 1'b0, "random");
    end
  endtask

  task automatic test_small_width();
    logic [7:0] b[$];
    logic [7:0] cur;
    int en0, base, t, bad;
`ifdef CONFIG_LOADER_CRC_EN
    logic [15:0] c;
`endif
    b = '{8'hC3, 8'h80};
`ifdef CONFIG_LOADER_CRC_EN
    c = crc_ref(b);
    b.push_back(c[15:8]);
    b.push_back(c[7:0]);
`endif
    @(posedge clock);
    en0  = en_s_total;
    base = bit_s_q.size();
    @(negedge clock) start_s = 1'b1;
    @(negedge clock) start_s = 1'b0;
    for (int i = 0; i < b.size(); i++) begin
      t = 0;
      while (s_ready_s !== 1'b1 && t < 40) begin
        @(negedge clock);
        t++;
      end
      repeat (3) @(negedge clock);
      if (i == 1) begin
        checks++;
        if (en_s_total - en0 != 8 || s_ready_s !== 1'b1) begin
          errors++;
          $display("FAIL small_gap shifts=%0d s_ready=%b required 8 1", en_s_total - en0, s_ready_s);
        end
      end
      s_valid_s = 1'b1;
      s_data_s  = b[i];
      @(posedge clock);
      #1 s_valid_s = 1'b0;
    end
    t = 0;
    while (done_s !== 1'b1 && t < 40) begin
      @(negedge clock);
      t++;
    end
    @(posedge clock);
    #1;
    checks++;
    if (done_s !== 1'b1 || error_s !== 1'b0 || en_s_total - en0 != WS) begin
      errors++;
      $display("FAIL small_end done=%b error=%b shifts=%0d required 1 0 %0d",
               done_s, error_s, en_s_total - en0, WS);
    end
    bad = 0;
    if (bit_s_q.size() < base + WS) bad = WS;
    else begin
      for (int i = 0; i < WS; i++) begin
        cur = b[i / 8];
        if (bit_s_q[base + i] !== cur[7 - (i % 8)]) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL small_bitstream wrong_bits=%0d required=0", bad);
    end
  endtask

  task automatic test_abort();
    logic [7:0] q[$];
    int en0;
    gen_bytes(q);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    for (int i = 0; i < 50; i++) push_byte(q[i], 0);
    repeat (2) @(negedge clock);
    checks++;
    if (cfg_enable !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre cfg_enable=%b required=1", cfg_enable);
    end
    abort = 1'b1;
    @(negedge clock) abort = 1'b0;
    checks++;
    if ({cfg_enable, busy, error, done, s_ready} !== 5'b00100) begin
      errors++;
      $display("FAIL abort_response got=%b required=00100", {cfg_enable, busy, error, done, s_ready});
    end
    @(posedge clock);
    en0 = en_total;
    repeat (12) @(negedge clock);
    @(posedge clock);
    checks++;
    if (en_total != en0 || error !== 1'b1) begin
      errors++;
      $display("FAIL abort_quiet extra_shifts=%0d error=%b required 0 1", en_total - en0, error);
    end
    @(negedge clock) begin start = 1'b1; abort = 1'b1; end
    @(negedge clock) begin start = 1'b0; abort = 1'b0; end
    checks++;
    if ({busy, error, cfg_nreset} !== 3'b100) begin
      errors++;
      $display("FAIL start_beats_abort got=%b required=100", {busy, error, cfg_nreset});
    end
    abort = 1'b1;
    @(negedge clock) abort = 1'b0;
    checks++;
    if ({busy, error} !== 2'b01) begin
      errors++;
      $display("FAIL abort_in_clear got=%b required=01", {busy, error});
    end
    gen_bytes(q);
    do_load(q, 1, 1'b0, 1'b0, "reload");
  endtask

  task automatic test_start_while_busy();
    logic [7:0] q[$];
    gen_bytes(q);
    do_load(q, 0, 1'b1, 1'b0, "spam");
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] q[$];
    int en0;
    gen_bytes(q);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    for (int i = 0; i < 10; i++) push_byte(q[i], 0);
    repeat (2) @(negedge clock);
    checks++;
    if (cfg_enable !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre cfg_enable=%b required=1", cfg_enable);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({s_ready, cfg_bit, cfg_enable, cfg_nreset, busy, done, error} !== 7'b0001000) begin
      errors++;
      $display("FAIL reset_async got=%b required=0001000",
               {s_ready, cfg_bit, cfg_enable, cfg_nreset, busy, done, error});
    end
    @(negedge clock);
    @(negedge clock) reset = 1'b0;
    @(posedge clock);
    en0 = en_total;
    repeat (20) @(negedge clock);
    @(posedge clock);
    checks++;
    if (en_total != en0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet extra_shifts=%0d busy=%b required 0 0", en_total - en0, busy);
    end
  endtask

`ifdef CONFIG_LOADER_CRC_EN
  task automatic test_crc_mismatch();
    logic [7:0] q[$];
    gen_bytes(q);
    do_load(q, 0, 1'b0, 1'b1, "crc_bad");
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_small_width();
    test_random_loads();
    test_abort();
    test_start_while_busy();
`ifdef CONFIG_LOADER_CRC_EN
    test_crc_mismatch();
`endif
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
